// File: rtl/calc_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package calc_pkg;

    localparam int ALU_W           = 16;
    localparam int NUM_REQ         = 2;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// on a tie the requester named by i_prio wins.
module alu_rr_pick
    import calc_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_prio,
    output logic [NUM_REQ-1:0] o_winner
);

    // One-hot winner from the request vector and the favoured index
    always_comb begin
        o_winner    = '0;
        o_winner[0] = i_req[0] & (~i_req[1] | ~i_prio);
        o_winner[1] = i_req[1] & (~i_req[0] |  i_prio);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle ALU. Operands are
// latched at grant time, the ALU is strobed once, and the result (or a
// timeout error) is returned to the served requester with a one-cycle done.
module alu_arbiter
    import calc_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ALU_W-1:0] op_a,
    input  logic [NUM_REQ*ALU_W-1:0] op_b,
    input  logic [NUM_REQ-1:0]       op_sub,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [ALU_W-1:0]         result,
    output logic                     ovf,
    output logic                     err,
    output logic                     busy,
    output logic [ALU_W-1:0]         alu_in1,
    output logic [ALU_W-1:0]         alu_in2,
    output logic                     alu_sub,
    output logic                     alu_start,
    input  logic [ALU_W-1:0]         alu_out,
    input  logic                     alu_finish
);

    // Timer value seen in the last permitted WAIT cycle
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic                 r_prio;          // index of the favoured requester
    logic [NUM_REQ-1:0]   r_gnt;
    logic [7:0]           r_timer;
    logic [ALU_W-1:0]     r_in1;
    logic [ALU_W-1:0]     r_in2;
    logic                 r_sub;
    logic [ALU_W-1:0]     r_result;
    logic                 r_ovf;
    logic                 r_err;

    logic [NUM_REQ-1:0]   w_winner;
    logic [ALU_W-1:0]     w_lane_a [NUM_REQ];
    logic [ALU_W-1:0]     w_lane_b [NUM_REQ];
    logic [ALU_W-1:0]     w_sel_a;
    logic [ALU_W-1:0]     w_sel_b;
    logic                 w_sel_sub;
    logic                 w_grant;
    logic                 w_start;
    logic                 w_capture;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   w_done;
    logic                 w_ovf;

    alu_rr_pick u_pick (
        .i_req    (req),
        .i_prio   (r_prio),
        .o_winner (w_winner)
    );

    // Split the packed operand buses into per-requester lanes
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_lane_a[gi] = op_a[gi*ALU_W +: ALU_W];
            assign w_lane_b[gi] = op_b[gi*ALU_W +: ALU_W];
        end
    endgenerate

    // AND-OR mux of the winning lane (winner is one-hot or zero)
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) begin
                w_sel_a   = w_sel_a | w_lane_a[i];
                w_sel_b   = w_sel_b | w_lane_b[i];
                w_sel_sub = w_sel_sub | op_sub[i];
            end
        end
    end

    // Signed overflow judged against the latched operands
    assign w_ovf = r_sub ? ((r_in1[ALU_W-1] != r_in2[ALU_W-1]) && (alu_out[ALU_W-1] != r_in1[ALU_W-1]))
                         : ((r_in1[ALU_W-1] == r_in2[ALU_W-1]) && (alu_out[ALU_W-1] != r_in1[ALU_W-1]));

    // State register
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state strobes; alu_finish only matters in WAIT
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_done       = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_start      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_finish) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESPOND;
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                w_done       = r_gnt;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Grant/operand latch, wait timer, result capture and pointer update
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_prio   <= 1'b0;
            r_gnt    <= '0;
            r_timer  <= '0;
            r_in1    <= '0;
            r_in2    <= '0;
            r_sub    <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt <= w_winner;
                r_in1 <= w_sel_a;
                r_in2 <= w_sel_b;
                r_sub <= w_sel_sub;
            end
            if (r_state == ST_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT && !alu_finish) begin
                r_timer <= r_timer + 8'd1;
            end
            if (w_capture) begin
                r_result <= alu_out;
                r_ovf    <= w_ovf;
                r_err    <= 1'b0;
            end else if (w_timeout) begin
                r_result <= '0;
                r_ovf    <= 1'b0;
                r_err    <= 1'b1;
            end
            if (r_state == ST_RESPOND) begin
                r_gnt  <= '0;
                r_prio <= r_gnt[0];   // served 0 -> favour 1, served 1 -> favour 0
            end
        end
    end

    assign gnt       = r_gnt;
    assign done      = w_done;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign err       = r_err;
    assign busy      = (r_state != ST_IDLE);
    assign alu_in1   = r_in1;
    assign alu_in2   = r_in2;
    assign alu_sub   = r_sub;
    assign alu_start = w_start;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table of operations driven
// through a bench ALU model, results checked via a scoreboard queue, plus
// hand-written reset sequences.
module tb_alu_arbiter;

    localparam int TO = 16;

    typedef struct {
        logic [1:0]  rq;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sub;
        int          lat;        // WAIT cycle of alu_finish, 0 = never
        bit          fin_issue;  // spurious alu_finish during ISSUE
        bit          drop;       // drop req right after the sample
        logic [1:0]  eg;
        logic [15:0] er;
        logic        eo;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [1:0]  g;
        logic [15:0] r;
        logic        o;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  req = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [1:0]  op_sub = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [15:0] result;
    logic        ovf;
    logic        err;
    logic        busy;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic        alu_sub;
    logic        alu_start;
    logic [15:0] alu_out = '0;
    logic        alu_finish = 1'b0;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_ops    = 0;
    exp_t sb[$];
    vec_t vt[13];

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
        .ovf        (ovf),
        .err        (err),
        .busy       (busy),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_sub    (alu_sub),
        .alu_start  (alu_start),
        .alu_out    (alu_out),
        .alu_finish (alu_finish)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full operation, started from an IDLE negedge, ending on the
    // IDLE negedge after done.
    task automatic do_op(input logic [1:0] rq, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sub, input int lat, input bit fin_issue,
                         input bit drop, input logic [1:0] eg, input logic [15:0] er,
                         input logic eo, input logic ee);
        exp_t        e;
        logic [15:0] la;
        logic [15:0] lb;
        logic        ls;
        int          wi;
        int          n;
        bit          seen;
        wi = eg[1] ? 1 : 0;
        la = a[wi*16 +: 16];
        lb = b[wi*16 +: 16];
        ls = sub[wi];
        e.g = eg; e.r = er; e.o = eo; e.e = ee;
        sb.push_back(e);
        req = rq; op_a = a; op_b = b; op_sub = sub;
        @(negedge clk);
        chk("issue_start", 32'(alu_start), 1);
        chk("issue_gnt", 32'(gnt), 32'(eg));
        chk("issue_in1", 32'(alu_in1), 32'(la));
        chk("issue_in2", 32'(alu_in2), 32'(lb));
        chk("issue_sub", 32'(alu_sub), 32'(ls));
        chk("issue_busy", 32'(busy), 1);
        op_a = ~a; op_b = ~b; op_sub = ~sub;
        if (drop) req = 2'b00;
        if (fin_issue) begin
            alu_finish = 1'b1;
            alu_out    = 16'hDEAD;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < TO + 8) begin
            @(negedge clk);
            n++;
            alu_finish = 1'b0;
            if (done != 2'b00) begin
                seen = 1'b1;
                chk("done_latency", 32'(n), 32'((lat > 0) ? lat + 1 : TO + 1));
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("done_bits", 32'(done), 32'(e.g));
                    chk("result", 32'(result), 32'(e.r));
                    chk("ovf", 32'(ovf), 32'(e.o));
                    chk("err", 32'(err), 32'(e.e));
                    chk("respond_gnt", 32'(gnt), 32'(e.g));
                    chk("hold_in1", 32'(alu_in1), 32'(la));
                    $display("op %0d: req=%b gnt=%b result=%h ovf=%b err=%b latency=%0d",
                             n_ops, rq, gnt, result, ovf, err, n);
                end
                n_ops++;
            end else begin
                chk("no_restart", 32'(alu_start), 0);
                if (lat > 0 && n == lat) begin
                    alu_finish = 1'b1;
                    alu_out    = ls ? (la - lb) : (la + lb);
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL done_wait: got no done expected done within %0d cycles", TO + 8);
            sb.delete();
        end
        @(negedge clk);
        chk("done_once", 32'(done), 0);
        chk("gnt_clear", 32'(gnt), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        //           rq     a             b             sub    lat fi dr eg     er        eo    ee
        vt[0]  = '{2'b11, 32'h0100_0005, 32'h0020_0003, 2'b10, 1,  0, 0, 2'b01, 16'h0008, 1'b0, 1'b0};
        vt[1]  = '{2'b11, 32'h0100_0005, 32'h0020_0003, 2'b10, 2,  0, 0, 2'b10, 16'h00E0, 1'b0, 1'b0};
        vt[2]  = '{2'b11, 32'h0100_0005, 32'h0020_0003, 2'b10, 1,  0, 0, 2'b01, 16'h0008, 1'b0, 1'b0};
        vt[3]  = '{2'b01, 32'h0000_0005, 32'h0000_0003, 2'b00, 1,  0, 0, 2'b01, 16'h0008, 1'b0, 1'b0};
        vt[4]  = '{2'b10, 32'h7FFF_0000, 32'h0001_0000, 2'b00, 1,  0, 0, 2'b10, 16'h8000, 1'b1, 1'b0};
        vt[5]  = '{2'b10, 32'h8000_0000, 32'h0001_0000, 2'b10, 4,  0, 0, 2'b10, 16'h7FFF, 1'b1, 1'b0};
        vt[6]  = '{2'b01, 32'h0000_1234, 32'h0000_1111, 2'b00, 0,  0, 0, 2'b01, 16'h0000, 1'b0, 1'b1};
        vt[7]  = '{2'b01, 32'h0000_FFFF, 32'h0000_0001, 2'b00, 1,  0, 0, 2'b01, 16'h0000, 1'b0, 1'b0};
        vt[8]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 2'b00, 2,  1, 0, 2'b10, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{2'b01, 32'h0000_4000, 32'h0000_4000, 2'b00, 16, 0, 0, 2'b01, 16'h8000, 1'b1, 1'b0};
        vt[10] = '{2'b01, 32'h0000_0003, 32'h0000_0005, 2'b01, 1,  0, 1, 2'b01, 16'hFFFE, 1'b0, 1'b0};
        vt[11] = '{2'b10, 32'h0000_0000, 32'h8000_0000, 2'b10, 1,  0, 0, 2'b10, 16'h8000, 1'b1, 1'b0};
        vt[12] = '{2'b01, 32'h0000_0001, 32'h0000_0001, 2'b00, 1,  0, 0, 2'b01, 16'h0002, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(alu_start), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'({ovf, err, alu_sub}), 0);
        chk("rst_in", 32'({alu_in1, alu_in2}), 0);
        nRST = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_op(vt[i].rq, vt[i].a, vt[i].b, vt[i].sub, vt[i].lat, vt[i].fin_issue,
                  vt[i].drop, vt[i].eg, vt[i].er, vt[i].eo, vt[i].ee);
        end

        // Reset in WAIT: operation abandoned, everything cleared at once
        req = 2'b01; op_a = 32'h0000_0042; op_b = 32'h0000_0001; op_sub = 2'b00;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        chk("wait_busy", 32'(busy), 1);
        #2 nRST = 1'b0;
        #1;
        chk("wrst_gnt", 32'(gnt), 0);
        chk("wrst_busy", 32'(busy), 0);
        chk("wrst_result", 32'(result), 0);
        chk("wrst_in1", 32'(alu_in1), 0);
        chk("wrst_done", 32'(done), 0);
        @(negedge clk);
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        // Pointer favoured 1 before reset; after reset a tie goes to 0
        do_op(2'b11, 32'h0009_0002, 32'h0004_0003, 2'b01, 1, 0, 0, 2'b01, 16'hFFFF, 1'b0, 1'b0);
        do_op(2'b10, 32'h0007_0000, 32'h0002_0000, 2'b00, 1, 0, 0, 2'b10, 16'h0009, 1'b0, 1'b0);

        // Reset in ISSUE: alu_start drops without waiting for a clock
        req = 2'b01; op_a = 32'h0000_0011; op_b = 32'h0000_0022; op_sub = 2'b00;
        @(negedge clk);
        req = 2'b00;
        chk("istart", 32'(alu_start), 1);
        #2 nRST = 1'b0;
        #1;
        chk("irst_start", 32'(alu_start), 0);
        chk("irst_gnt", 32'(gnt), 0);
        @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        chk("irst_done", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles before an operation is aborted with an error; legal range 2..255.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 req  in  2  per-requester request level; bit i = requester i.
REQ-005 op_a  in  32  operand A per requester; lane i = bits [16i+15:16i], signed two's complement.
REQ-006 op_b  in  32  operand B per requester; same lane layout as op_a.
REQ-007 op_sub  in  2  per-requester operation select; 1 = A-B, 0 = A+B.
REQ-008 gnt  out  2  one-hot grant; high from ISSUE through RESPOND for the served requester.
REQ-009 done  out  2  one-cycle completion pulse to the served requester.
REQ-010 result  out  16  result of the last completed operation; valid while done is high, held until the next done.
REQ-011 ovf  out  1  signed overflow of the last operation; valid with done.
REQ-012 err  out  1  timeout flag of the last operation; valid with done.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 alu_in1 / alu_in2  out  16 each  registered operands to the shared ALU.
REQ-015 alu_sub  out  1  registered operation select to the ALU.
REQ-016 alu_start  out  1  single-cycle ALU start strobe.
REQ-017 alu_out  in  16  ALU result.
REQ-018 alu_finish  in  1  ALU completion strobe.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESPOND.
REQ-020 IDLE: req sampled only here; if any bit set, pick winner, latch its lane into alu_in1/alu_in2/alu_sub, set gnt, go ISSUE; otherwise stay.
REQ-021 Arbitration: single request wins outright; with both set, the requester not served last wins; after reset requester 0 is favoured.
REQ-022 The round-robin pointer SHALL update only in RESPOND, including error completions.
REQ-023 ISSUE: alu_start = 1 for exactly this one cycle; timer cleared; go WAIT unconditionally.
REQ-024 alu_finish during IDLE, ISSUE or RESPOND SHALL be ignored.
REQ-025 WAIT: on alu_finish capture alu_out into result, compute ovf, err = 0, go RESPOND.
REQ-026 WAIT without alu_finish: increment timer; when timer reaches TIMEOUT-1, set result = 0, ovf = 0, err = 1, go RESPOND.
REQ-027 alu_finish in the same cycle as the timeout SHALL take priority (normal completion, err = 0).
REQ-028 ovf for add = (a[15]==b[15]) and (r[15]!=a[15]); for subtract = (a[15]!=b[15]) and (r[15]!=a[15]); a, b are the latched operands.
REQ-029 RESPOND: done bit of the granted requester high for one cycle; gnt cleared on exit; go IDLE.
REQ-030 Minimum latency: req high in IDLE (cycle 0) -> alu_start cycle 1 -> finish earliest seen cycle 2 -> done cycle 3.
REQ-031 Requesters hold req and operands until done; operands changing after the IDLE sample SHALL NOT affect the operation.
REQ-032 Deassertion of req after the IDLE sample SHALL NOT cancel the operation; done still pulses.
REQ-033 req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-034 alu_in1/alu_in2/alu_sub SHALL hold their values from ISSUE until the next grant.

Reset
REQ-035 nRST low SHALL immediately force: state IDLE, pointer favouring requester 0, timer 0, all outputs 0.
REQ-036 Reset mid-operation SHALL abandon it with no done pulse; alu_start drops asynchronously.

Structure
REQ-037 Package calc_pkg SHALL hold: arb_state_t enum, ALU_W = 16, NUM_REQ = 2, TIMEOUT_DEFAULT = 16.
REQ-038 One sub-module, alu_rr_pick (combinational 2-way round-robin picker: req, pointer -> one-hot winner), SHALL be instantiated; overflow logic stays inline.

Verification
REQ-039 req=01, A=0x0005, B=0x0003, add, ALU finishes 1 cycle after start -> alu_start cycle 1, done=01 cycle 3, result 0x0008, ovf 0, err 0.
REQ-040 req=11 held continuously across three operations -> grant order 0,1,0; each done bit pulses exactly once per operation.
REQ-041 requester 1, A=0x7FFF, B=0x0001, add -> result 0x8000, ovf 1; A=0x8000, B=0x0001, subtract -> result 0x7FFF, ovf 1.
REQ-042 alu_finish never asserted, TIMEOUT=16 -> done 16 WAIT cycles after start, err 1, result 0x0000; next request served normally.
REQ-043 nRST low during WAIT -> outputs 0 immediately, no done pulse; after release, req=10 gets granted (pointer reset).
REQ-044 alu_finish asserted during ISSUE only, then again in WAIT -> ISSUE strobe ignored, completion on the WAIT strobe.
